// File: rtl/seg_scan_arbiter.sv
// Eight-digit multiplexed 7-segment scanner with a two-port round-robin
// write arbiter in front of the digit store.
module seg_scan_arbiter #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       wr0_valid,
  input  logic [2:0] wr0_addr,
  input  logic [4:0] wr0_data,
  output logic       wr0_ready,
  input  logic       wr1_valid,
  input  logic [2:0] wr1_addr,
  input  logic [4:0] wr1_data,
  output logic       wr1_ready,
  input  logic [7:0] digit_en,
  output logic [7:0] seg_com,
  output logic [7:0] seg_data,
  output logic       frame_tick
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST_P  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_P = PW'(BLANK_CYC);

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_DRIVE = 1'b1;

  logic [PW-1:0] pcnt;
  logic [2:0]    idx;
  logic [4:0]    store [8];
  logic          prio;   // 1 = port 1 wins a tie
  logic          state;
  logic          wrap;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [4:0]    wr_data;
  logic [4:0]    cur;

  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Grants are gated by rst so nothing is acknowledged while held in reset.
  always_comb begin
    wr0_ready = rst & wr0_valid & (~wr1_valid | ~prio);
    wr1_ready = rst & wr1_valid & (~wr0_valid | prio);
    wr_en     = wr0_ready | wr1_ready;
    wr_addr   = wr1_ready ? wr1_addr : wr0_addr;
    wr_data   = wr1_ready ? wr1_data : wr0_data;
  end

  always_comb begin
    wrap  = (pcnt == LAST_P);
    state = (pcnt < BLANK_P) ? ST_BLANK : ST_DRIVE;
    cur   = store[idx];
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 8; i++) store[i] <= '0;
      prio <= 1'b0;
    end else if (wr_en) begin
      store[wr_addr] <= wr_data;
      prio           <= ~wr1_ready;
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      pcnt       <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      pcnt       <= wrap ? '0 : pcnt + 1'b1;
      idx        <= idx + {2'b00, wrap};
      frame_tick <= wrap && (idx == 3'd7);
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      seg_com  <= '1;
      seg_data <= '0;
    end else if (state == ST_DRIVE && digit_en[idx]) begin
      seg_com  <= ~(8'd1 << idx);
      seg_data <= {cur[4], seg7(cur[3:0])};
    end else begin
      seg_com  <= '1;
      seg_data <= '0;
    end
  end

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed bench for seg_scan_arbiter with SCAN_DIV=8, BLANK_CYC=2.
module tb_seg_scan_arbiter;

  logic       mclk = 1'b0;
  logic       rst = 1'b0;
  logic       wr0_valid = 1'b0;
  logic [2:0] wr0_addr = '0;
  logic [4:0] wr0_data = '0;
  logic       wr0_ready;
  logic       wr1_valid = 1'b0;
  logic [2:0] wr1_addr = '0;
  logic [4:0] wr1_data = '0;
  logic       wr1_ready;
  logic [7:0] digit_en = 8'hFF;
  logic [7:0] seg_com;
  logic [7:0] seg_data;
  logic       frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] seven [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};

  seg_scan_arbiter #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .mclk(mclk), .rst(rst),
    .wr0_valid(wr0_valid), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ready(wr0_ready),
    .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
    .digit_en(digit_en), .seg_com(seg_com), .seg_data(seg_data), .frame_tick(frame_tick)
  );

  always #5 mclk = ~mclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic put0(input logic [2:0] a, input logic [4:0] d);
    wr0_valid = 1'b1; wr0_addr = a; wr0_data = d;
    @(negedge mclk);
    wr0_valid = 1'b0;
  endtask

  // Leaves the bench at the negedge just after the idx 7->0 edge (k=0).
  task automatic wait_frame;
    int t;
    t = 0;
    do begin
      @(negedge mclk);
      t++;
    end while (frame_tick !== 1'b1 && t < 200);
    n_cmp++;
    if (frame_tick !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_wait: frame_tick=%b after %0d cycles, required 1", frame_tick, t);
    end
  endtask

  task automatic test_reset;
    step(2);
    n_cmp++; if (seg_com !== 8'hFF) begin n_bad++; $display("FAIL rst_hold_com: got %h required ff", seg_com); end
    n_cmp++; if (seg_data !== 8'h00) begin n_bad++; $display("FAIL rst_hold_data: got %h required 00", seg_data); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL rst_hold_tick: got %b required 0", frame_tick); end
    rst = 1'b1;
    step(3);
    put0(3'd0, 5'h08);
    step(5);
    wr0_valid = 1'b1; wr0_addr = 3'd1; wr0_data = 5'h08;
    wr1_valid = 1'b1; wr1_addr = 3'd6; wr1_data = 5'h08;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (wr0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready0: got %b required 0", wr0_ready); end
    n_cmp++; if (wr1_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready1: got %b required 0", wr1_ready); end
    n_cmp++; if (seg_com !== 8'hFF) begin n_bad++; $display("FAIL rst_async_com: got %h required ff", seg_com); end
    n_cmp++; if (seg_data !== 8'h00) begin n_bad++; $display("FAIL rst_async_data: got %h required 00", seg_data); end
    @(negedge mclk);
    wr0_valid = 1'b0; wr1_valid = 1'b0;
    rst = 1'b1;
    step(2);
    n_cmp++; if (seg_com !== 8'hFF) begin n_bad++; $display("FAIL rst_blank_com: got %h required ff", seg_com); end
    n_cmp++; if (seg_data !== 8'h00) begin n_bad++; $display("FAIL rst_blank_data: got %h required 00", seg_data); end
    step(1);
    n_cmp++; if (seg_com !== 8'hFE) begin n_bad++; $display("FAIL rst_first_com: got %h required fe", seg_com); end
    n_cmp++; if (seg_data !== 8'h3F) begin n_bad++; $display("FAIL rst_first_data: got %h required 3f", seg_data); end
    step(8);
    n_cmp++; if (seg_com !== 8'hFD) begin n_bad++; $display("FAIL rst_lost_com: got %h required fd", seg_com); end
    n_cmp++; if (seg_data !== 8'h3F) begin n_bad++; $display("FAIL rst_lost_data: got %h required 3f", seg_data); end
  endtask

  task automatic test_scan;
    logic [7:0] ec, ed;
    logic       et;
    int pc, ix;
    for (int n = 0; n < 8; n++) put0(3'(n), 5'(n));
    wait_frame();
    for (int k = 1; k <= 65; k++) begin
      step(1);
      pc = (k - 1) % 8;
      ix = ((k - 1) / 8) % 8;
      ec = (pc < 2) ? 8'hFF : (8'hFF ^ (8'd1 << ix));
      ed = (pc < 2) ? 8'h00 : seven[ix];
      et = (k == 64);
      n_cmp++; if (seg_com !== ec) begin n_bad++; $display("FAIL scan_com k=%0d: got %h required %h", k, seg_com, ec); end
      n_cmp++; if (seg_data !== ed) begin n_bad++; $display("FAIL scan_data k=%0d: got %h required %h", k, seg_data, ed); end
      n_cmp++; if (frame_tick !== et) begin n_bad++; $display("FAIL scan_tick k=%0d: got %b required %b", k, frame_tick, et); end
    end
  endtask

  task automatic test_live_write;
    wait_frame();
    step(27);
    wr0_valid = 1'b1; wr0_addr = 3'd3; wr0_data = 5'h1A;
    #1;
    n_cmp++; if (wr0_ready !== 1'b1) begin n_bad++; $display("FAIL live_ready: got %b required 1", wr0_ready); end
    @(negedge mclk);
    wr0_valid = 1'b0;
    n_cmp++; if (seg_data !== 8'h4F) begin n_bad++; $display("FAIL live_old: got %h required 4f", seg_data); end
    step(1);
    n_cmp++; if (seg_data !== 8'hF7) begin n_bad++; $display("FAIL live_new: got %h required f7", seg_data); end
    n_cmp++; if (seg_com !== 8'hF7) begin n_bad++; $display("FAIL live_com: got %h required f7", seg_com); end
    step(1);
    put0(3'd0, 5'h09);
    n_cmp++; if (seg_data !== 8'hF7) begin n_bad++; $display("FAIL other_addr_a: got %h required f7", seg_data); end
    step(1);
    n_cmp++; if (seg_data !== 8'hF7) begin n_bad++; $display("FAIL other_addr_b: got %h required f7", seg_data); end
    put0(3'd4, 5'h0E);
    n_cmp++; if (seg_com !== 8'hFF) begin n_bad++; $display("FAIL blank_wr_com: got %h required ff", seg_com); end
    n_cmp++; if (seg_data !== 8'h00) begin n_bad++; $display("FAIL blank_wr_data: got %h required 00", seg_data); end
    step(2);
    n_cmp++; if (seg_com !== 8'hEF) begin n_bad++; $display("FAIL blank_wr_show_com: got %h required ef", seg_com); end
    n_cmp++; if (seg_data !== 8'h79) begin n_bad++; $display("FAIL blank_wr_show_data: got %h required 79", seg_data); end
  endtask

  task automatic test_disable_wrap;
    digit_en = 8'h7F;
    wait_frame();
    step(51);
    n_cmp++; if (seg_com !== 8'hBF) begin n_bad++; $display("FAIL dis_d6_com: got %h required bf", seg_com); end
    n_cmp++; if (seg_data !== 8'h7D) begin n_bad++; $display("FAIL dis_d6_data: got %h required 7d", seg_data); end
    step(8);
    n_cmp++; if (seg_com !== 8'hFF) begin n_bad++; $display("FAIL dis_d7_com: got %h required ff", seg_com); end
    n_cmp++; if (seg_data !== 8'h00) begin n_bad++; $display("FAIL dis_d7_data: got %h required 00", seg_data); end
    step(5);
    n_cmp++; if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL dis_wrap_tick: got %b required 1", frame_tick); end
    n_cmp++; if (seg_com !== 8'hFF) begin n_bad++; $display("FAIL dis_wrap_com: got %h required ff", seg_com); end
    step(3);
    n_cmp++; if (seg_com !== 8'hFE) begin n_bad++; $display("FAIL dis_d0_com: got %h required fe", seg_com); end
    n_cmp++; if (seg_data !== 8'h6F) begin n_bad++; $display("FAIL dis_d0_data: got %h required 6f", seg_data); end
    wait_frame();
    step(59);
    digit_en = 8'hFF;
    step(1);
    n_cmp++; if (seg_com !== 8'h7F) begin n_bad++; $display("FAIL en_now_com: got %h required 7f", seg_com); end
    n_cmp++; if (seg_data !== 8'h07) begin n_bad++; $display("FAIL en_now_data: got %h required 07", seg_data); end
  endtask

  task automatic test_arbitration;
    @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
    rst = 1'b1;
    wr0_valid = 1'b1; wr0_addr = 3'd2; wr0_data = 5'h01;
    wr1_valid = 1'b1; wr1_addr = 3'd5; wr1_data = 5'h12;
    #1;
    n_cmp++; if ({wr0_ready, wr1_ready} !== 2'b10) begin n_bad++; $display("FAIL arb_g1: got %b required 10", {wr0_ready, wr1_ready}); end
    @(negedge mclk);
    n_cmp++; if ({wr0_ready, wr1_ready} !== 2'b01) begin n_bad++; $display("FAIL arb_g2: got %b required 01", {wr0_ready, wr1_ready}); end
    @(negedge mclk);
    wr0_data = 5'h03;
    n_cmp++; if ({wr0_ready, wr1_ready} !== 2'b10) begin n_bad++; $display("FAIL arb_g3: got %b required 10", {wr0_ready, wr1_ready}); end
    @(negedge mclk);
    wr0_valid = 1'b0; wr1_valid = 1'b0;
    @(negedge mclk);
    wr0_valid = 1'b1; wr1_valid = 1'b1;
    #1;
    n_cmp++; if ({wr0_ready, wr1_ready} !== 2'b01) begin n_bad++; $display("FAIL arb_ptr: got %b required 01", {wr0_ready, wr1_ready}); end
    #1;
    wr0_valid = 1'b0; wr1_valid = 1'b0;
    wait_frame();
    step(19);
    n_cmp++; if (seg_com !== 8'hFB) begin n_bad++; $display("FAIL arb_d2_com: got %h required fb", seg_com); end
    n_cmp++; if (seg_data !== 8'h4F) begin n_bad++; $display("FAIL arb_d2_data: got %h required 4f", seg_data); end
    step(24);
    n_cmp++; if (seg_com !== 8'hDF) begin n_bad++; $display("FAIL arb_d5_com: got %h required df", seg_com); end
    n_cmp++; if (seg_data !== 8'hDB) begin n_bad++; $display("FAIL arb_d5_data: got %h required db", seg_data); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_live_write();
    test_disable_wrap();
    test_arbitration();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_arbiter.md
SEG_SCAN_ARBITER -- requirements
Module: seg_scan_arbiter

Interface
REQ-001 The block SHALL have a parameter SCAN_DIV, default 1000, giving the mclk cycles per digit slot; legal values are 2 or more.
REQ-002 The block SHALL have a parameter BLANK_CYC, default 16, giving the blanking cycles at the start of each slot; legal values are 0 to SCAN_DIV-1.
REQ-003 Port mclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port wr0_valid, input, 1 bit: requester 0 write request.
REQ-006 Port wr0_addr, input, 3 bits: requester 0 digit index, 0 to 7.
REQ-007 Port wr0_data, input, 5 bits: requester 0 digit value as {dp, hex[3:0]}.
REQ-008 Port wr0_ready, output, 1 bit: requester 0 grant.
REQ-009 Ports wr1_valid, wr1_addr, wr1_data and wr1_ready SHALL be identical to the requester 0 ports, for requester 1.
REQ-010 Port digit_en, input, 8 bits: per-digit display enable; 1 means the digit is shown.
REQ-011 Port seg_com, output, 8 bits: digit commons, active-low, one-cold; bit n drives digit n.
REQ-012 Port seg_data, output, 8 bits: segments, active-high, ordered {dp,g,f,e,d,c,b,a}.
REQ-013 Port frame_tick, output, 1 bit: one-cycle pulse at the end of each full 8-digit scan.

Function
REQ-014 An 8-entry by 5-bit digit store SHALL hold the display contents.
REQ-015 Grant, combinational: wrN_ready SHALL be high only when wrN_valid is high and port N wins arbitration; at most one ready is high per cycle.
REQ-016 Only one valid requester: that requester SHALL be granted.
REQ-017 Both requesters valid: the port not granted most recently SHALL win (round-robin); after reset, port 0 wins first.
REQ-018 The round-robin pointer SHALL update only on an accepted write (valid and ready both high).
REQ-019 An accepted write SHALL update store[addr] on the same clock edge; the losing requester holds its request.
REQ-020 Prescaler pcnt SHALL count 0 to SCAN_DIV-1 and then wrap to 0.
REQ-021 On each pcnt wrap, digit index idx SHALL increment modulo 8 (7 then 0).
REQ-022 frame_tick SHALL be high for exactly the one cycle following the idx 7-to-0 transition.
REQ-023 Slot FSM, BLANK state (pcnt < BLANK_CYC): the registered outputs SHALL be seg_com=8'hFF and seg_data=8'h00.
REQ-024 Slot FSM, DRIVE state (pcnt >= BLANK_CYC), digit enabled (digit_en[idx]=1): seg_com SHALL be ~(1<<idx) and seg_data SHALL be decode(store[idx]).
REQ-025 Slot FSM, DRIVE state, digit disabled (digit_en[idx]=0): seg_com SHALL be 8'hFF and seg_data SHALL be 8'h00.
REQ-026 Outputs SHALL be registered, one cycle after the pcnt/idx state that produces them.
REQ-027 A write to store[idx] during DRIVE SHALL appear on seg_data 1 cycle after the write edge.
REQ-028 Decode, bits g..a, SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-029 Decode SHALL set bit7 equal to the dp bit.
REQ-030 A digit_en change SHALL take effect on the next output register update, with no wait for the slot boundary.
REQ-031 A write during BLANK, or a write to a non-current digit, SHALL be stored and SHALL NOT disturb the outputs.

Reset
REQ-032 While rst=0, asynchronously: seg_com=8'hFF, seg_data=8'h00, frame_tick=0, pcnt=0, idx=0, round-robin pointer favours port 0, all store entries 0.
REQ-033 While rst=0, wr0_ready and wr1_ready SHALL be 0.
REQ-034 Reset asserted mid-slot or mid-write SHALL abort immediately, and the write SHALL be lost.
REQ-035 After rst rises, scanning SHALL restart at idx=0 with a full BLANK period.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-036 Scenario, reset: pulse rst low mid-slot -> seg_com=FF and seg_data=00 at once; after release, first DRIVE shows seg_com=FE with seg_data=3F.
REQ-037 Scenario, scan: digit_en=FF and store[n]=n -> seg_com steps FE,FD,...,7F every 8 cycles with 2 blank cycles each; frame_tick pulses every 64 cycles.
REQ-038 Scenario, arbitration: both ports valid for 3 cycles, port 0 to addr 2 and port 1 to addr 5 -> grants alternate 0,1,0.
REQ-039 Scenario, arbitration result: after REQ-038, store[2] and store[5] hold the written values, and the pointer favours port 1.
REQ-040 Scenario, live write: during DRIVE of digit 3, write {1,4'hA} to addr 3 -> seg_data=F7 one cycle after the write edge.
REQ-041 Scenario, disable and wrap: digit_en=8'h7F -> digit 7 slot shows seg_com=FF, and idx still wraps 7 to 0 with frame_tick.
